// File: rtl/op_aut_mc.sv
// op_aut_mc: multi-cycle MIPS-style datapath (FETCH/DECODE/EXEC/WB) with req/ack instruction fetch.
// Ports: clock/reset (async, active-high); imem_req/imem_addr/imem_ack/imem_data fetch handshake;
// rd_mux_s, write, op2_mux_s, alu_funct, branch_mux_s from the control unit;
// opcode/funct/zero and decode/exec/retire state strobes to the control unit.
// Optional macro OP_AUT_MC_JUMP_EN: opcode 0x02 performs a J-type jump with no register write.
module op_aut_mc #(
  parameter int WIDTH = 32,
  parameter int REGS = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clock,
  input  logic             reset,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_data,
  input  logic             rd_mux_s,
  input  logic             write,
  input  logic             op2_mux_s,
  input  logic [5:0]       alu_funct,
  input  logic             branch_mux_s,
  output logic [5:0]       opcode,
  output logic [5:0]       funct,
  output logic             zero,
  output logic             decode,
  output logic             exec,
  output logic             retire
);
  localparam int AW = $clog2(REGS);
  typedef enum logic [1:0] {FETCH, DECODE, EXEC, WB} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d, a_q, a_d, b_q, b_d, alu_q, alu_d;
  logic [31:0] ir_q, ir_d;
  logic [4:0] dest_q, dest_d;
  logic [WIDTH-1:0] rf_q [REGS];
  logic [WIDTH-1:0] imm, op2, res, pc4, rs_v, rt_v;
  logic jmp, we;
`ifdef OP_AUT_MC_JUMP_EN
  assign jmp = ir_q[31:26] == 6'h02;
`else
  assign jmp = 1'b0;
`endif
  // reg[0] is never written and resets to 0, so it reads 0 without a special case
  assign rs_v = (ir_q[25:21] >> AW) == 5'd0 ? rf_q[ir_q[21 +: AW]] : '0;
  assign rt_v = (ir_q[20:16] >> AW) == 5'd0 ? rf_q[ir_q[16 +: AW]] : '0;
  assign imm = {{(WIDTH-16){ir_q[15]}}, ir_q[15:0]};
  assign op2 = op2_mux_s ? imm : b_q;
  assign pc4 = pc_q + {{(WIDTH-3){1'b0}}, 3'd4};
  assign we = state_q == WB && write && !jmp && dest_q != 5'd0 && (dest_q >> AW) == 5'd0;
  assign zero = res == '0;
  assign imem_req = state_q == FETCH;
  assign imem_addr = pc_q;
  assign opcode = ir_q[31:26];
  assign funct = ir_q[5:0];
  assign decode = state_q == DECODE;
  assign exec = state_q == EXEC;
  assign retire = state_q == WB;
  always_comb begin
    res = '0;
    case (alu_funct)
      6'h20: res = a_q + op2;
      6'h22: res = a_q - op2;
      6'h24: res = a_q & op2;
      6'h25: res = a_q | op2;
      6'h26: res = a_q ^ op2;
      6'h27: res = ~(a_q | op2);
      6'h2A: res = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(op2)};
      6'h00: res = op2 << ir_q[10:6];
      default: res = '0;
    endcase
  end
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    a_d = a_q;
    b_d = b_q;
    alu_d = alu_q;
    dest_d = dest_q;
    case (state_q)
      FETCH: begin
        ir_d = imem_ack ? imem_data : ir_q;
        state_d = imem_ack ? DECODE : FETCH;
      end
      DECODE: begin
        a_d = rs_v;
        b_d = rt_v;
        state_d = EXEC;
      end
      EXEC: begin
        alu_d = res;
        dest_d = rd_mux_s ? ir_q[15:11] : ir_q[20:16];
        pc_d = jmp ? {pc4[WIDTH-1:28], ir_q[25:0], 2'b00} : branch_mux_s ? pc4 + (imm << 2) : pc4;
        state_d = WB;
      end
      default: state_d = FETCH;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q <= RESET_PC;
      ir_q <= '0;
      a_q <= '0;
      b_q <= '0;
      alu_q <= '0;
      dest_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      a_q <= a_d;
      b_q <= b_d;
      alu_q <= alu_d;
      dest_q <= dest_d;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REGS; i++) rf_q[i] <= '0;
    end else if (we) begin
      rf_q[dest_q[AW-1:0]] <= alu_q;
    end
  end
endmodule
